// File: rtl/alu_result_stage.sv
// -----------------------------------------------------------------------------
// alu_result_stage
//
// Purpose:
//   Two-entry elastic buffer between Execute and Memory for ALU results.
//   - MAIN is the entry presented downstream.
//   - SKID absorbs one extra result when Memory stalls.
//   - in_ready is taken straight from a flop, so it never depends
//     combinationally on out_ready.
//   - Both held entries are also exposed to the operand forwarding logic.
//
// Ports:
//   clock, reset           rising-edge clock; asynchronous active-high reset
//   flush                  synchronous discard of all held results
//   in_valid/in_ready      handshake from Execute; payload in_result, in_rd,
//                          in_rd_we
//   out_valid/out_ready    handshake to Memory; payload out_result, out_rd,
//                          out_rd_we
//   fwd_rs{1,2}_addr       source registers queried by operand select
//   fwd_rs{1,2}_hit/_data  match flag and forwarded value (SKID wins)
// -----------------------------------------------------------------------------
module alu_result_stage #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  flush,

  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [XLEN-1:0]       in_result,
  input  logic [REG_ADDR_W-1:0] in_rd,
  input  logic                  in_rd_we,

  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [XLEN-1:0]       out_result,
  output logic [REG_ADDR_W-1:0] out_rd,
  output logic                  out_rd_we,

  input  logic [REG_ADDR_W-1:0] fwd_rs1_addr,
  input  logic [REG_ADDR_W-1:0] fwd_rs2_addr,
  output logic                  fwd_rs1_hit,
  output logic                  fwd_rs2_hit,
  output logic [XLEN-1:0]       fwd_rs1_data,
  output logic [XLEN-1:0]       fwd_rs2_data
);

  // Entry storage. The occupancy state is encoded by the two valid bits:
  //   EMPTY = !main, ONE = main & !skid, FULL = main & skid.
  // SKID is never valid while MAIN is invalid.
  logic                  r_main_valid;
  logic [XLEN-1:0]       r_main_result;
  logic [REG_ADDR_W-1:0] r_main_rd;
  logic                  r_main_we;

  logic                  r_skid_valid;
  logic [XLEN-1:0]       r_skid_result;
  logic [REG_ADDR_W-1:0] r_skid_rd;
  logic                  r_skid_we;

  logic w_push;
  logic w_pop;

  assign in_ready   = ~r_skid_valid;
  assign out_valid  = r_main_valid;
  assign out_result = r_main_result;
  assign out_rd     = r_main_rd;
  assign out_rd_we  = r_main_we;

  assign w_push = in_valid & ~r_skid_valid;
  assign w_pop  = r_main_valid & out_ready;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_main_valid  <= 1'b0;
      r_main_result <= '0;
      r_main_rd     <= '0;
      r_main_we     <= 1'b0;
      r_skid_valid  <= 1'b0;
      r_skid_result <= '0;
      r_skid_rd     <= '0;
      r_skid_we     <= 1'b0;
    end else if (flush) begin
      // Data is cleared along with valid, so stale results never reach out_*.
      r_main_valid  <= 1'b0;
      r_main_result <= '0;
      r_main_rd     <= '0;
      r_main_we     <= 1'b0;
      r_skid_valid  <= 1'b0;
      r_skid_result <= '0;
      r_skid_rd     <= '0;
      r_skid_we     <= 1'b0;
    end else if (r_skid_valid) begin
      // FULL: only a pop can happen; SKID moves up into MAIN.
      if (w_pop) begin
        r_main_result <= r_skid_result;
        r_main_rd     <= r_skid_rd;
        r_main_we     <= r_skid_we;
        r_skid_valid  <= 1'b0;
      end
    end else if (r_main_valid) begin
      // ONE
      if (w_push && w_pop) begin
        // Replace MAIN directly so a steady stream sees no bubble.
        r_main_result <= in_result;
        r_main_rd     <= in_rd;
        r_main_we     <= in_rd_we;
      end else if (w_push) begin
        r_skid_valid  <= 1'b1;
        r_skid_result <= in_result;
        r_skid_rd     <= in_rd;
        r_skid_we     <= in_rd_we;
      end else if (w_pop) begin
        r_main_valid  <= 1'b0;
      end
    end else if (w_push) begin
      // EMPTY
      r_main_valid  <= 1'b1;
      r_main_result <= in_result;
      r_main_rd     <= in_rd;
      r_main_we     <= in_rd_we;
    end
  end

  // Forwarding: only registered entries are considered. Register 0 never
  // matches. When both entries match, SKID holds the younger value.
  logic [1:0]            w_main_match;
  logic [1:0]            w_skid_match;
  logic [REG_ADDR_W-1:0] w_query [2];
  logic [1:0]            w_hit;
  logic [XLEN-1:0]       w_data  [2];

  assign w_query[0] = fwd_rs1_addr;
  assign w_query[1] = fwd_rs2_addr;

  for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
    assign w_main_match[gi] = r_main_valid & r_main_we &
                              (r_main_rd == w_query[gi]) & (w_query[gi] != '0);
    assign w_skid_match[gi] = r_skid_valid & r_skid_we &
                              (r_skid_rd == w_query[gi]) & (w_query[gi] != '0);
    assign w_hit[gi]  = w_main_match[gi] | w_skid_match[gi];
    assign w_data[gi] = w_skid_match[gi] ? r_skid_result :
                        w_main_match[gi] ? r_main_result : '0;
  end

  assign fwd_rs1_hit  = w_hit[0];
  assign fwd_rs2_hit  = w_hit[1];
  assign fwd_rs1_data = w_data[0];
  assign fwd_rs2_data = w_data[1];

endmodule

// File: tb/tb_alu_result_stage.sv
module tb_alu_result_stage;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  logic                  clock = 1'b0;
  logic                  reset;
  logic                  flush;
  logic                  in_valid;
  logic                  in_ready;
  logic [XLEN-1:0]       in_result;
  logic [REG_ADDR_W-1:0] in_rd;
  logic                  in_rd_we;
  logic                  out_valid;
  logic                  out_ready;
  logic [XLEN-1:0]       out_result;
  logic [REG_ADDR_W-1:0] out_rd;
  logic                  out_rd_we;
  logic [REG_ADDR_W-1:0] fwd_rs1_addr;
  logic [REG_ADDR_W-1:0] fwd_rs2_addr;
  logic                  fwd_rs1_hit;
  logic                  fwd_rs2_hit;
  logic [XLEN-1:0]       fwd_rs1_data;
  logic [XLEN-1:0]       fwd_rs2_data;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clock = ~clock;

  alu_result_stage #(.XLEN(XLEN), .REG_ADDR_W(REG_ADDR_W)) dut (
    .clock        (clock),
    .reset        (reset),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_result    (in_result),
    .in_rd        (in_rd),
    .in_rd_we     (in_rd_we),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_result   (out_result),
    .out_rd       (out_rd),
    .out_rd_we    (out_rd_we),
    .fwd_rs1_addr (fwd_rs1_addr),
    .fwd_rs2_addr (fwd_rs2_addr),
    .fwd_rs1_hit  (fwd_rs1_hit),
    .fwd_rs2_hit  (fwd_rs2_hit),
    .fwd_rs1_data (fwd_rs1_data),
    .fwd_rs2_data (fwd_rs2_data)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) begin
      $display("ok   %-24s observed=0x%0h", tag, obs);
    end else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock edge and settle 1 time unit after it.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic [XLEN-1:0] res,
                       input logic [REG_ADDR_W-1:0] rd, input logic we);
    in_valid  = v;
    in_result = res;
    in_rd     = rd;
    in_rd_we  = we;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    flush = 1'b0;
    out_ready = 1'b0;
    fwd_rs1_addr = '0;
    fwd_rs2_addr = '0;
    drive(1'b0, '0, '0, 1'b0);
    #3;
    // Reset state
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_result", out_result, 0);
    check("rst_out_rd", out_rd, 0);
    check("rst_fwd1_hit", fwd_rs1_hit, 0);
    @(negedge clock);
    reset = 1'b0;

    // Streaming 0x11, 0x22, 0x33
    out_ready = 1'b1;
    drive(1'b1, 32'h11, 5'd1, 1'b1);
    tick();
    check("stream_v1", out_valid, 1);
    check("stream_d1", out_result, 32'h11);
    check("stream_rdy1", in_ready, 1);
    drive(1'b1, 32'h22, 5'd2, 1'b1);
    tick();
    check("stream_d2", out_result, 32'h22);
    check("stream_rdy2", in_ready, 1);
    drive(1'b1, 32'h33, 5'd3, 1'b1);
    tick();
    check("stream_d3", out_result, 32'h33);
    check("stream_rd3", out_rd, 3);
    check("stream_rdy3", in_ready, 1);
    drive(1'b0, '0, '0, 1'b0);
    tick();
    check("stream_drain", out_valid, 0);

    // Backpressure 0xA (rd3), 0xB (rd4)
    out_ready = 1'b0;
    drive(1'b1, 32'hA, 5'd3, 1'b1);
    tick();
    check("bp_one_rdy", in_ready, 1);
    check("bp_one_d", out_result, 32'hA);
    drive(1'b1, 32'hB, 5'd4, 1'b1);
    tick();
    check("bp_full_rdy", in_ready, 0);
    check("bp_full_d", out_result, 32'hA);
    drive(1'b0, '0, '0, 1'b0);
    fwd_rs1_addr = 5'd3;
    fwd_rs2_addr = 5'd4;
    #1;
    check("bp_fwd1_data", fwd_rs1_data, 32'hA);
    check("bp_fwd2_data", fwd_rs2_data, 32'hB);
    tick();
    check("bp_hold_d", out_result, 32'hA);
    check("bp_hold_rdy", in_ready, 0);
    out_ready = 1'b1;
    tick();
    check("bp_pop1_d", out_result, 32'hB);
    check("bp_pop1_rd", out_rd, 4);
    check("bp_pop1_rdy", in_ready, 1);
    tick();
    check("bp_pop2_v", out_valid, 0);

    // Forward priority: MAIN rd5=0x100, SKID rd5=0x200
    out_ready = 1'b0;
    drive(1'b1, 32'h100, 5'd5, 1'b1);
    tick();
    drive(1'b1, 32'h200, 5'd5, 1'b1);
    tick();
    drive(1'b0, '0, '0, 1'b0);
    fwd_rs1_addr = 5'd5;
    fwd_rs2_addr = 5'd6;
    #1;
    check("prio_hit1", fwd_rs1_hit, 1);
    check("prio_data1", fwd_rs1_data, 32'h200);
    check("prio_hit2", fwd_rs2_hit, 0);
    check("prio_data2", fwd_rs2_data, 0);

    // Flush in FULL with in_valid=1
    flush = 1'b1;
    drive(1'b1, 32'h999, 5'd5, 1'b1);
    tick();
    flush = 1'b0;
    drive(1'b0, '0, '0, 1'b0);
    check("flush_v", out_valid, 0);
    check("flush_rdy", in_ready, 1);
    check("flush_hit1", fwd_rs1_hit, 0);
    check("flush_hit2", fwd_rs2_hit, 0);

    // x0 and no-write entries
    drive(1'b1, 32'h55, 5'd0, 1'b1);
    tick();
    drive(1'b1, 32'h77, 5'd7, 1'b0);
    tick();
    drive(1'b0, '0, '0, 1'b0);
    fwd_rs1_addr = 5'd0;
    fwd_rs2_addr = 5'd7;
    #1;
    check("x0_hit", fwd_rs1_hit, 0);
    check("x0_data", fwd_rs1_data, 0);
    check("nowe_hit", fwd_rs2_hit, 0);
    check("x0_full_rdy", in_ready, 0);

    // Async reset pulse between edges while FULL
    #1;
    reset = 1'b1;
    #1;
    check("areset_v", out_valid, 0);
    check("areset_rdy", in_ready, 1);
    check("areset_rd", out_rd, 0);
    @(negedge clock);
    reset = 1'b0;

    // First push after reset accepted at the first edge
    out_ready = 1'b1;
    drive(1'b1, 32'h42, 5'd9, 1'b1);
    tick();
    check("post_rst_v", out_valid, 1);
    check("post_rst_d", out_result, 32'h42);
    drive(1'b0, '0, '0, 1'b0);
    tick();
    check("post_rst_pop", out_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
